// File: rtl/lab_logic_inverse.sv
// Inverse solver for the lab function F(a,b,c) -> (x,y): given a target (x,y),
// streams every {a,b,c} in ascending order whose forward image equals the target.
module lab_logic_inverse #(
    parameter bit EMIT_ALL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       x_in,
    input  logic       y_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] abc_out,
    output logic       out_last,
    output logic       done,
    output logic [3:0] match_count,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  mask_q, mask_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  hit;
    logic [3:0]  hit_cnt;
    logic [7:0]  upper;
    logic        last_c;

    // Local copy of the forward function, evaluated for all eight input codes.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_fwd
            localparam logic [2:0] ABC = 3'(gi);
            logic fa, fb, fc, fx, fy;
            assign fa = ABC[2];
            assign fb = ABC[1];
            assign fc = ABC[0];
            assign fx = ~fc ^ (fa | fb);
            assign fy = (fa | fb) & (~(fa & fb) ^ (fa | fb));
            assign hit[gi] = (fx == x_in) && (fy == y_in);
        end
    endgenerate

    always_comb begin
        hit_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            hit_cnt = hit_cnt + {3'd0, hit[i]};
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        upper   = mask_q >> idx_q;
        // Last beat when single-shot, or when no matching code remains above idx.
        last_c  = !EMIT_ALL || (upper[7:1] == 7'd0);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mask_d  = hit;
                    cnt_d   = hit_cnt;
                    idx_d   = 3'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (mask_q[idx_q]) begin
                    state_d = EMIT;
                end else if (idx_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_c) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SCAN;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            mask_q  <= 8'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready    = (state_q == IDLE) && !rst;
    assign out_valid   = (state_q == EMIT);
    assign abc_out     = out_valid ? idx_q : 3'd0;
    assign out_last    = out_valid && last_c;
    assign done        = (state_q == DONE);
    assign match_count = done ? cnt_q : 4'd0;
    assign busy        = (state_q != IDLE);

endmodule
